// File: rtl/uart_bridge_pkg.sv
// Shared definitions for the UART-to-memory bridge: command codes and FSM state encoding.
`timescale 1ns/1ps
package uart_bridge_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_READ  = 8'h02;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_WRITE,
        ST_READ_WAIT,
        ST_TX_LOAD,
        ST_TX_HOLD,
        ST_TX_WAIT
    } state_t;

endpackage

// File: rtl/uart_mem_bridge.sv
// Byte-serial command bridge: decodes write/read packets from a UART into memory
// accesses and streams read data back out through the UART transmitter.
`timescale 1ns/1ps
module uart_mem_bridge
    import uart_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1000000
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_re,
    input  logic [7:0]            rx_data,
    input  logic                  tx_busy,
    output logic                  tx_start,
    output logic [7:0]            tx_data,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  err
);

    localparam int ADDR_BYTES = (ADDR_WIDTH + 7) / 8;
    localparam int DATA_BYTES = (DATA_WIDTH + 7) / 8;
    localparam int AW         = ADDR_BYTES * 8;
    localparam int DW         = DATA_BYTES * 8;
    localparam int TO_W       = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [TO_W-1:0] TO_RELOAD = TO_W'(TIMEOUT_CYCLES);
    localparam logic [7:0]      ADDR_LAST = 8'(ADDR_BYTES - 1);
    localparam logic [7:0]      DATA_LAST = 8'(DATA_BYTES - 1);

    state_t          r_state;
    logic            r_rx_re_d;
    logic            r_is_write;
    logic [7:0]      r_byte_cnt;
    logic [TO_W-1:0] r_timeout;
    logic [AW-1:0]   r_addr_sh;
    logic [DW-1:0]   r_wdata_sh;
    logic [DW-1:0]   r_tx_sh;
    logic            r_tx_start;
    logic [7:0]      r_tx_data;
    logic            r_mem_we;
    logic            r_err;

    state_t          w_state_nxt;
    logic            w_byte_valid;
    logic            w_err;
    logic            w_tx_start;
    logic            w_addr_shift;
    logic            w_data_shift;
    logic            w_cnt_clr;
    logic            w_cnt_inc;
    logic            w_tx_load;
    logic            w_tx_shift;
    logic [DW-1:0]   w_rdata_ext;

    assign w_byte_valid = rx_re & ~r_rx_re_d;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // NOTE: every signal gets a default before the case, so no path leaves one unassigned (no latches).
    always_comb begin
        w_state_nxt  = r_state;
        w_err        = 1'b0;
        w_tx_start   = 1'b0;
        w_addr_shift = 1'b0;
        w_data_shift = 1'b0;
        w_cnt_clr    = 1'b0;
        w_cnt_inc    = 1'b0;
        w_tx_load    = 1'b0;
        w_tx_shift   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_byte_valid) begin
                    if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
                        w_state_nxt = ST_ADDR;
                        w_cnt_clr   = 1'b1;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            ST_ADDR: begin
                if (w_byte_valid) begin
                    w_addr_shift = 1'b1;
                    if (r_byte_cnt == ADDR_LAST) begin
                        w_cnt_clr   = 1'b1;
                        w_state_nxt = r_is_write ? ST_DATA : ST_READ_WAIT;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end else if (r_timeout == '0) begin
                    w_err       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (w_byte_valid) begin
                    w_data_shift = 1'b1;
                    if (r_byte_cnt == DATA_LAST) begin
                        w_cnt_clr   = 1'b1;
                        w_state_nxt = ST_WRITE;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end else if (r_timeout == '0) begin
                    w_err       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WRITE: begin
                w_err       = w_byte_valid;
                w_state_nxt = ST_IDLE;
            end
            ST_READ_WAIT: begin
                w_err       = w_byte_valid;
                w_tx_load   = 1'b1;
                w_cnt_clr   = 1'b1;
                w_state_nxt = ST_TX_LOAD;
            end
            ST_TX_LOAD: begin
                w_err = w_byte_valid;
                if (!tx_busy) begin
                    w_tx_start  = 1'b1;
                    w_state_nxt = ST_TX_HOLD;
                end
            end
            ST_TX_HOLD: begin
                w_err       = w_byte_valid;
                w_state_nxt = ST_TX_WAIT;
            end
            ST_TX_WAIT: begin
                w_err = w_byte_valid;
                if (!tx_busy) begin
                    w_tx_shift = 1'b1;
                    if (r_byte_cnt == DATA_LAST) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_cnt_inc   = 1'b1;
                        w_state_nxt = ST_TX_LOAD;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_rdata_ext                 = '0;
        w_rdata_ext[DATA_WIDTH-1:0] = mem_rdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_re_d  <= 1'b0;
            r_is_write <= 1'b0;
            r_byte_cnt <= '0;
            r_addr_sh  <= '0;
            r_wdata_sh <= '0;
            r_tx_sh    <= '0;
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
            r_mem_we   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_rx_re_d  <= rx_re;
            r_tx_start <= w_tx_start;
            r_mem_we   <= (w_state_nxt == ST_WRITE);
            r_err      <= w_err;
            if (r_state == ST_IDLE && w_byte_valid)
                r_is_write <= (rx_data == CMD_WRITE);
            if (w_cnt_clr)      r_byte_cnt <= '0;
            else if (w_cnt_inc) r_byte_cnt <= r_byte_cnt + 8'd1;
            if (w_addr_shift) r_addr_sh  <= (r_addr_sh << 8) | AW'(rx_data);
            if (w_data_shift) r_wdata_sh <= (r_wdata_sh << 8) | DW'(rx_data);
            if (w_tx_load)       r_tx_sh <= w_rdata_ext;
            else if (w_tx_shift) r_tx_sh <= r_tx_sh << 8;
            if (w_tx_start) r_tx_data <= r_tx_sh[DW-1 -: 8];
        end
    end

    // A byte arriving on the very cycle the counter hits zero still wins and reloads it.
    always_ff @(posedge clk) begin
        if (reset || r_state == ST_IDLE || w_byte_valid)
            r_timeout <= TO_RELOAD;
        else if ((r_state == ST_ADDR || r_state == ST_DATA) && r_timeout != '0)
            r_timeout <= r_timeout - 1'b1;
    end

    assign tx_start  = r_tx_start;
    assign tx_data   = r_tx_data;
    assign mem_addr  = r_addr_sh[ADDR_WIDTH-1:0];
    assign mem_wdata = r_wdata_sh[DATA_WIDTH-1:0];
    assign mem_we    = r_mem_we;
    assign err       = r_err;

endmodule

// File: tb/tb_uart_mem_bridge.sv
// Directed bench for uart_mem_bridge: packet table plus hand-written read, timeout and reset sequences.
`timescale 1ns/1ps
module tb_uart_mem_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_re;
    logic [7:0]  rx_data;
    logic        tx_busy;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;
    logic        err;

    int total = 0;
    int bad   = 0;

    uart_mem_bridge #(
        .ADDR_WIDTH    (16),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_re    (rx_re),
        .rx_data  (rx_data),
        .tx_busy  (tx_busy),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_we   (mem_we),
        .mem_rdata(mem_rdata),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Memory model: one known word, every other address returns a pattern of itself.
    assign mem_rdata = (mem_addr == 16'h1234) ? 32'hCAFEF00D : {mem_addr, mem_addr ^ 16'hA5A5};

    // UART transmitter model: busy for six cycles after each start.
    int busy_cnt = 0;
    always @(posedge clk) begin
        if (tx_start)          busy_cnt <= 6;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0);

    int          we_cnt  = 0;
    int          err_cnt = 0;
    int          viol    = 0;
    logic [15:0] we_addr = '0;
    logic [31:0] we_data = '0;
    logic        prev_start = 1'b0;
    logic        prev_we    = 1'b0;
    logic [7:0]  tx_q[$];

    always @(negedge clk) begin
        if (mem_we) begin
            we_cnt++;
            we_addr = mem_addr;
            we_data = mem_wdata;
            if (prev_we) viol++;
        end
        if (err) err_cnt++;
        if (tx_start) begin
            tx_q.push_back(tx_data);
            if (tx_busy || prev_start) viol++;
        end
        prev_start = tx_start;
        prev_we    = mem_we;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(posedge clk); #1;
        rx_data = b;
        rx_re   = 1'b1;
        repeat (2) @(posedge clk);
        #1 rx_re = 1'b0;
        repeat (2 + gap) @(posedge clk);
    endtask

    task automatic wait_tx(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (tx_q.size() >= n) break;
        end
    endtask

    typedef struct {
        int          n;
        logic [55:0] bytes;
        int          exp_we;
        int          exp_err;
        logic [15:0] exp_addr;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int we0, err0, tx0;
        vecs[0] = '{7, 56'h01_1234_DEADBEEF, 1, 0, 16'h1234, 32'hDEADBEEF};
        vecs[1] = '{1, 56'h55_0000_00000000, 0, 1, 16'h1234, 32'hDEADBEEF};
        vecs[2] = '{7, 56'h01_0000_00000001, 1, 0, 16'h0000, 32'h00000001};
        vecs[3] = '{7, 56'h01_FFFF_FFFFFFFF, 1, 0, 16'hFFFF, 32'hFFFFFFFF};
        vecs[4] = '{1, 56'h00_0000_00000000, 0, 1, 16'hFFFF, 32'hFFFFFFFF};
        vecs[5] = '{1, 56'hFF_0000_00000000, 0, 1, 16'hFFFF, 32'hFFFFFFFF};
        vecs[6] = '{7, 56'h01_ABCD_12345678, 1, 0, 16'hABCD, 32'h12345678};
        vecs[7] = '{1, 56'h03_0000_00000000, 0, 1, 16'hABCD, 32'h12345678};

        reset   = 1'b1;
        rx_re   = 1'b0;
        rx_data = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset tx_start",  {63'd0, tx_start}, 64'd0);
        check("reset mem_we",    {63'd0, mem_we},   64'd0);
        check("reset err",       {63'd0, err},      64'd0);
        check("reset tx_data",   64'(tx_data),      64'd0);
        check("reset mem_addr",  64'(mem_addr),     64'd0);
        check("reset mem_wdata", 64'(mem_wdata),    64'd0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (2) @(posedge clk);

        for (int v = 0; v < 8; v++) begin
            we0 = we_cnt; err0 = err_cnt; tx0 = tx_q.size();
            for (int i = 0; i < vecs[v].n; i++) send_byte(vecs[v].bytes[55 - 8*i -: 8], 0);
            repeat (6) @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d we count", v),  64'(we_cnt - we0),       64'(vecs[v].exp_we));
            check($sformatf("vec%0d err count", v), 64'(err_cnt - err0),     64'(vecs[v].exp_err));
            check($sformatf("vec%0d tx count", v),  64'(tx_q.size() - tx0),  64'd0);
            check($sformatf("vec%0d mem_addr", v),  64'(mem_addr),           64'(vecs[v].exp_addr));
            check($sformatf("vec%0d mem_wdata", v), 64'(mem_wdata),          64'(vecs[v].exp_data));
            if (vecs[v].exp_we != 0) begin
                check($sformatf("vec%0d addr at we", v), 64'(we_addr), 64'(vecs[v].exp_addr));
                check($sformatf("vec%0d data at we", v), 64'(we_data), 64'(vecs[v].exp_data));
            end
        end

        // Read of the known word.
        tx_q.delete();
        we0 = we_cnt; err0 = err_cnt;
        send_byte(8'h02, 0); send_byte(8'h12, 0); send_byte(8'h34, 0);
        wait_tx(4, 200);
        repeat (20) @(negedge clk);
        check("read1 tx count", 64'(tx_q.size()), 64'd4);
        if (tx_q.size() == 4) begin
            check("read1 byte0", 64'(tx_q[0]), 64'hCA);
            check("read1 byte1", 64'(tx_q[1]), 64'hFE);
            check("read1 byte2", 64'(tx_q[2]), 64'hF0);
            check("read1 byte3", 64'(tx_q[3]), 64'h0D);
        end
        check("read1 no we",  64'(we_cnt - we0),   64'd0);
        check("read1 no err", 64'(err_cnt - err0), 64'd0);

        // Read of a patterned address.
        tx_q.delete();
        send_byte(8'h02, 0); send_byte(8'h00, 0); send_byte(8'h10, 0);
        wait_tx(4, 200);
        repeat (20) @(negedge clk);
        check("read2 tx count", 64'(tx_q.size()), 64'd4);
        if (tx_q.size() == 4)
            check("read2 bytes", 64'({tx_q[0], tx_q[1], tx_q[2], tx_q[3]}), 64'h0010A5B5);

        // Inter-byte timeout, then a stray byte in IDLE.
        we0 = we_cnt; err0 = err_cnt;
        send_byte(8'h01, 0); send_byte(8'h12, 0);
        repeat (85) @(negedge clk);
        check("timeout not early", 64'(err_cnt - err0), 64'd0);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (err_cnt != err0) break;
        end
        check("timeout err", 64'(err_cnt - err0), 64'd1);
        send_byte(8'h34, 0);
        repeat (4) @(negedge clk);
        check("after timeout err", 64'(err_cnt - err0), 64'd2);
        check("timeout no we",     64'(we_cnt - we0),   64'd0);

        // rx_re held high must yield a single byte.
        err0 = err_cnt;
        @(posedge clk); #1;
        rx_data = 8'h55;
        rx_re   = 1'b1;
        repeat (50) @(posedge clk);
        #1 rx_re = 1'b0;
        repeat (4) @(negedge clk);
        check("held rx_re one byte", 64'(err_cnt - err0), 64'd1);

        // Slow sender stays inside the timeout window.
        we0 = we_cnt; err0 = err_cnt;
        send_byte(8'h01, 80); send_byte(8'h00, 80); send_byte(8'h42, 80);
        send_byte(8'h11, 80); send_byte(8'h22, 80); send_byte(8'h33, 80);
        send_byte(8'h44, 4);
        @(negedge clk);
        check("slow write we",   64'(we_cnt - we0),   64'd1);
        check("slow write err",  64'(err_cnt - err0), 64'd0);
        check("slow write addr", 64'(we_addr), 64'h0042);
        check("slow write data", 64'(we_data), 64'h11223344);

        // Reset while waiting on the second transmitted byte.
        tx_q.delete();
        send_byte(8'h02, 0); send_byte(8'h12, 0); send_byte(8'h34, 0);
        wait_tx(2, 200);
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        we0 = we_cnt;
        repeat (60) @(negedge clk);
        check("reset abort tx count", 64'(tx_q.size()), 64'd2);
        check("reset abort no we",    64'(we_cnt - we0), 64'd0);
        check("reset abort mem_addr", 64'(mem_addr),     64'd0);
        send_byte(8'h01, 0); send_byte(8'h12, 0); send_byte(8'h34, 0);
        send_byte(8'hDE, 0); send_byte(8'hAD, 0); send_byte(8'hBE, 0);
        send_byte(8'hEF, 4);
        @(negedge clk);
        check("post-reset write we",   64'(we_cnt - we0), 64'd1);
        check("post-reset write data", 64'(we_data), 64'hDEADBEEF);
        check("post-reset tx count",   64'(tx_q.size()), 64'd2);

        check("strobe protocol violations", 64'(viol), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_mem_bridge.md
UART_MEM_BRIDGE -- requirements
Module: uart_mem_bridge

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, memory address width; ADDR_BYTES = ceil(ADDR_WIDTH/8).
REQ-002 Parameter DATA_WIDTH, default 32, memory word width; DATA_BYTES = ceil(DATA_WIDTH/8).
REQ-003 Parameter TIMEOUT_CYCLES, default 1000000, inter-byte timeout within a packet.
REQ-004 clk  input  1  clock; all logic on posedge clk.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 rx_re  input  1  UART receive-done level; a new byte is flagged by its rising edge.
REQ-007 rx_data  input  8  received byte; valid while rx_re is high.
REQ-008 tx_busy  input  1  UART transmitter busy.
REQ-009 tx_start  output  1  one-cycle transmit request.
REQ-010 tx_data  output  8  byte to transmit; valid in the tx_start cycle.
REQ-011 mem_addr  output  ADDR_WIDTH  memory address.
REQ-012 mem_wdata  output  DATA_WIDTH  memory write data.
REQ-013 mem_we  output  1  one-cycle write strobe.
REQ-014 mem_rdata  input  DATA_WIDTH  read data, valid 1 cycle after mem_addr is stable.
REQ-015 err  output  1  one-cycle protocol-error pulse.

Function
REQ-016 Byte strobe: rx_re delayed by one register; byte_valid = rx_re & ~rx_re_d; a held-high rx_re yields exactly one byte.
REQ-017 Packet format: command byte, ADDR_BYTES address bytes MSB first, then for write DATA_BYTES data bytes MSB first; command codes 0x01 = WRITE, 0x02 = READ.
REQ-018 States: IDLE, ADDR, DATA, WRITE, READ_WAIT, TX_LOAD, TX_HOLD, TX_WAIT.
REQ-019 IDLE: byte_valid with 0x01 or 0x02 -> ADDR with byte counter cleared; any other value -> err pulse, stay IDLE.
REQ-020 ADDR: each byte shifts into the address register from the LSB end; after ADDR_BYTES bytes -> DATA (write) or READ_WAIT (read); only the low ADDR_WIDTH bits drive mem_addr.
REQ-021 DATA: each byte shifts into the wdata register the same way; after DATA_BYTES bytes -> WRITE.
REQ-022 WRITE: mem_we = 1 for exactly one cycle with the final mem_addr and mem_wdata -> IDLE; no response byte is sent.
REQ-023 READ_WAIT: one cycle; at its end mem_rdata is captured into the tx shift register -> TX_LOAD.
REQ-024 TX_LOAD: when tx_busy = 0, tx_start = 1 for one cycle with tx_data = top byte of the shift register -> TX_HOLD.
REQ-025 TX_HOLD: one cycle, tx_start = 0, so the UART busy flag can rise -> TX_WAIT.
REQ-026 TX_WAIT: when tx_busy = 0, shift the register left 8 bits and count the byte; DATA_BYTES sent -> IDLE, else -> TX_LOAD.
REQ-027 Timeout counter: reloads to TIMEOUT_CYCLES on every byte_valid and in IDLE; decrements in ADDR/DATA; at zero -> err pulse, IDLE, partial packet discarded.
REQ-028 byte_valid in WRITE, READ_WAIT or any TX state: byte dropped, err pulse, state unaffected.
REQ-029 byte_valid and timeout expiry in the same cycle: the byte is accepted and the counter reloads.
REQ-030 mem_addr and mem_wdata hold their values between packets; outputs are registered.

Reset
REQ-031 On reset: state IDLE; tx_start, mem_we, err = 0; tx_data, mem_addr, mem_wdata = 0; rx_re_d = 0; byte and timeout counters cleared/reloaded.
REQ-032 Reset mid-packet or mid-transmit aborts the transaction; no further tx_start or mem_we is issued until a new packet arrives.

Structure
REQ-033 Shared package uart_bridge_pkg holds CMD_WRITE = 0x01, CMD_READ = 0x02 and the state encoding.
REQ-034 No sub-module; the existing UART is instantiated beside the bridge at the level above.

Verification (ADDR_WIDTH=16, DATA_WIDTH=32, TIMEOUT_CYCLES=100)
REQ-035 Bytes 01 12 34 DE AD BE EF -> single mem_we cycle with mem_addr = 0x1234 and mem_wdata = 0xDEADBEEF; tx_start never asserted.
REQ-036 Bytes 02 12 34, mem_rdata = 0xCAFEF00D -> tx bytes CA FE F0 0D in order; each tx_start is one cycle and occurs with tx_busy = 0.
REQ-037 Byte 0x55 in IDLE -> one err pulse, no mem_we; the following write packet completes correctly.
REQ-038 Bytes 01 12 then 100 idle cycles -> err pulse, IDLE; a subsequent byte 0x34 gives another err.
REQ-039 reset asserted in TX_WAIT after the second read byte -> tx_start stays 0, state IDLE, and no remaining bytes are sent.
REQ-040 rx_re held high for 50 cycles -> exactly one byte consumed.
